// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM state type and default width for serial_adder_ctrl
package serial_adder_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   localparam int DEFAULT_WIDTH = 8;
endpackage

// File: rtl/serial_adder_ctrl_fa_cell.sv
// fa_cell: one-bit full adder built from two half adders and an or gate
module halfadder (
   input  logic a,
   input  logic b,
   output logic sum,
   output logic cout
);
   assign sum  = a ^ b;
   assign cout = a & b;
endmodule

module fa_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);
   logic s0, c0, c1;
   halfadder u_h0 (.a(a),  .b(b),   .sum(s0),  .cout(c0));
   halfadder u_h1 (.a(s0), .b(cin), .sum(sum), .cout(c1));
   or u_or (cout, c0, c1);
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder, LSB first, one bit per clock, WIDTH+1 cycle latency
// SERIAL_ADDER_SUB_EN adds a sub input selecting a - b (inverted b, initial carry 1)
module serial_adder_ctrl
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   state_t state;
   logic [WIDTH-1:0] ra, rb;
   logic [CW-1:0] cnt;
   logic carry, b_bit, s, c, cin0;
`ifdef SERIAL_ADDER_SUB_EN
   logic sub_r;
   assign b_bit = rb[0] ^ sub_r;
   assign cin0  = sub;
`else
   assign b_bit = rb[0];
   assign cin0  = 1'b0;
`endif
   fa_cell u_fa (.a(ra[0]), .b(b_bit), .cin(carry), .sum(s), .cout(c));
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         sum   <= '0;
         cout  <= 1'b0;
         cnt   <= '0;
         carry <= 1'b0;
         ra    <= '0;
         rb    <= '0;
`ifdef SERIAL_ADDER_SUB_EN
         sub_r <= 1'b0;
`endif
      end else
         case (state)
            IDLE: if (start) begin
               ra    <= a;
               rb    <= b;
               sum   <= '0;
               cnt   <= '0;
               carry <= cin0;
               busy  <= 1'b1;
               state <= RUN;
`ifdef SERIAL_ADDER_SUB_EN
               sub_r <= sub;
`endif
            end
            RUN: begin
               ra    <= ra >> 1;
               rb    <= rb >> 1;
               sum   <= {s, sum[WIDTH-1:1]};
               carry <= c;
               cnt   <= cnt + CW'(1);
               if (cnt == LAST) begin
                  cout  <= c;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed self-checking bench for serial_adder_ctrl (WIDTH=8)
module tb_serial_adder_ctrl;
   logic clk = 1'b0, rst = 1'b1, start = 1'b0, sub = 1'b0;
   logic [7:0] a = '0, b = '0, sum;
   logic busy, done, cout;
   int passed = 0, total = 0;

   serial_adder_ctrl #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .start(start),
`ifdef SERIAL_ADDER_SUB_EN
      .sub(sub),
`endif
      .a(a), .b(b), .busy(busy), .done(done), .sum(sum), .cout(cout)
   );

   always #5 clk = ~clk;

   // accept one operation, then count edges to done and cycles busy was seen high
   task automatic do_op(input logic [7:0] av, input logic [7:0] bv, output int n, output int bn);
      @(negedge clk);
      a = av; b = bv; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n = 0; bn = 0;
      while (!done && n < 40) begin
         if (busy) bn++;
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic test_reset;
      #2;
      total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
      total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
      total++; if (sum !== 8'h00) $display("FAIL reset_sum got %h want 00", sum); else passed++;
      total++; if (cout !== 1'b0) $display("FAIL reset_cout got %b want 0", cout); else passed++;
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_add_basic;
      int n, bn;
      do_op(8'h0F, 8'h01, n, bn);
      total++; if (n !== 8) $display("FAIL basic_latency got %0d want 8", n); else passed++;
      total++; if (bn !== 8) $display("FAIL basic_busy_cycles got %0d want 8", bn); else passed++;
      total++; if (sum !== 8'h10) $display("FAIL basic_sum got %h want 10", sum); else passed++;
      total++; if (cout !== 1'b0) $display("FAIL basic_cout got %b want 0", cout); else passed++;
      @(posedge clk); #1;
      total++; if (done !== 1'b0) $display("FAIL basic_done_width got %b want 0", done); else passed++;
   endtask

   task automatic test_overflow_hold;
      int n, bn;
      do_op(8'hFF, 8'h01, n, bn);
      total++; if (n !== 8) $display("FAIL ovf_latency got %0d want 8", n); else passed++;
      total++; if (sum !== 8'h00) $display("FAIL ovf_sum got %h want 00", sum); else passed++;
      total++; if (cout !== 1'b1) $display("FAIL ovf_cout got %b want 1", cout); else passed++;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         total++;
         if (sum !== 8'h00 || cout !== 1'b1 || done !== 1'b0 || busy !== 1'b0)
            $display("FAIL ovf_hold cycle %0d got sum=%h cout=%b done=%b busy=%b want 00/1/0/0", i, sum, cout, done, busy);
         else passed++;
      end
   endtask

   task automatic test_back_to_back;
      int first = -1, second = -1, ndone = 0;
      logic prev = 1'b0, wide = 1'b0, sum_ok = 1'b1;
      @(negedge clk);
      a = 8'h03; b = 8'h04; start = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         if (done) begin
            if (ndone == 0) first = i;
            if (ndone == 1) second = i;
            ndone++;
            if (sum !== 8'h07) sum_ok = 1'b0;
         end
         if (done && prev) wide = 1'b1;
         prev = done;
      end
      start = 1'b0;
      total++; if (first !== 8) $display("FAIL b2b_first_done got %0d want 8", first); else passed++;
      total++; if (second !== 18) $display("FAIL b2b_second_done got %0d want 18", second); else passed++;
      total++; if (ndone !== 3) $display("FAIL b2b_done_count got %0d want 3", ndone); else passed++;
      total++; if (wide !== 1'b0) $display("FAIL b2b_done_width got %b want 0", wide); else passed++;
      total++; if (sum_ok !== 1'b1) $display("FAIL b2b_sum got %h want 07", sum); else passed++;
   endtask

   task automatic test_async_reset;
      int n, bn;
      logic seen = 1'b0;
      @(negedge clk);
      a = 8'hFF; b = 8'h00; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || cout !== 1'b0)
         $display("FAIL arst_outputs got busy=%b done=%b sum=%h cout=%b want 0/0/00/0", busy, done, sum, cout);
      else passed++;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (done || busy) seen = 1'b1;
      end
      total++; if (seen !== 1'b0) $display("FAIL arst_no_done got %b want 0", seen); else passed++;
      do_op(8'h20, 8'h22, n, bn);
      total++; if (n !== 8) $display("FAIL arst_latency got %0d want 8", n); else passed++;
      total++; if (sum !== 8'h42) $display("FAIL arst_sum got %h want 42", sum); else passed++;
      total++; if (cout !== 1'b0) $display("FAIL arst_cout got %b want 0", cout); else passed++;
   endtask

`ifdef SERIAL_ADDER_SUB_EN
   task automatic test_sub;
      int n, bn;
      sub = 1'b1;
      do_op(8'h05, 8'h07, n, bn);
      total++; if (sum !== 8'hFE) $display("FAIL sub_borrow_sum got %h want fe", sum); else passed++;
      total++; if (cout !== 1'b0) $display("FAIL sub_borrow_cout got %b want 0", cout); else passed++;
      do_op(8'h07, 8'h05, n, bn);
      total++; if (sum !== 8'h02) $display("FAIL sub_sum got %h want 02", sum); else passed++;
      total++; if (cout !== 1'b1) $display("FAIL sub_cout got %b want 1", cout); else passed++;
      sub = 1'b0;
      do_op(8'h05, 8'h07, n, bn);
      total++; if (sum !== 8'h0C) $display("FAIL sub0_sum got %h want 0c", sum); else passed++;
   endtask
`endif

   initial begin
      test_reset;
      test_add_basic;
      test_overflow_hold;
      test_back_to_back;
      test_async_reset;
`ifdef SERIAL_ADDER_SUB_EN
      test_sub;
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin an operation; sampled only in IDLE.
REQ-005 The block SHALL have ports a and b, input, WIDTH bits each: operands, captured on the edge that accepts start.
REQ-006 The block SHALL have port busy, output, 1 bit: high in RUN.
REQ-007 The block SHALL have port done, output, 1 bit: high for exactly one cycle, in DONE.
REQ-008 The block SHALL have port sum, output, WIDTH bits: result register.
REQ-009 The block SHALL have port cout, output, 1 bit: final carry-out.

Function
REQ-010 The block SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-011 In IDLE with start=1, the block SHALL on that edge do all of the following: load a and b into operand shift registers; clear sum; clear bit counter; set carry to 0 (to 1 when subtracting, see REQ-021); go to RUN.
REQ-012 In IDLE with start=0, state and all registers SHALL hold.
REQ-013 In RUN, each edge SHALL add operand bit 0s plus the carry register, and update state as follows:
- sum bit shifts into sum MSB, sum shifts right;
- operands shift right;
- carry register is updated;
- counter increments.
REQ-014 The edge that processes bit WIDTH-1 (counter = WIDTH-1) SHALL load cout with the final carry and go to DONE.
REQ-015 done SHALL rise on the WIDTH-th rising edge after the edge that accepted start; total start-to-done latency is WIDTH+1 cycles.
REQ-016 DONE SHALL last exactly one cycle, then return to IDLE unconditionally.
REQ-017 start asserted in RUN or DONE SHALL be ignored; no queuing.
REQ-018 sum and cout SHALL be undefined for use during RUN, and valid from DONE until the next accepted start, holding their values through IDLE.
REQ-019 Arithmetic SHALL be modulo 2^WIDTH, with the carry beyond the MSB reported only on cout.

Reset
REQ-020 While rst=1, state SHALL be IDLE and busy, done, sum, cout, counter, carry and the operand registers SHALL be 0, asynchronously; this applies at any time, including mid-RUN, where the operation is abandoned without a done pulse.

Configuration
REQ-021 With macro SERIAL_ADDER_SUB_EN defined, the block SHALL have an extra input sub (1 bit), captured with start.
- sub=1: the block computes a - b by inverting the b bits entering the adder and setting the initial carry to 1; cout=1 means no borrow.
- sub=0: behaviour is identical to add.
REQ-022 Without SERIAL_ADDER_SUB_EN, the sub port and inversion logic SHALL be absent and the block SHALL add only.

Structure
REQ-023 Package serial_adder_pkg SHALL hold the FSM state typedef (IDLE/RUN/DONE) and the default WIDTH constant.
REQ-024 The one-bit adder SHALL be sub-module fa_cell (ports a, b, cin, sum, cout), built structurally from two halfadder instances and an or gate.

Verification
REQ-025 WIDTH=8, reset, then start with a=8'h0F, b=8'h01 -> done high 8 edges after acceptance; sum=8'h10, cout=0; busy high for 8 cycles.
REQ-026 a=8'hFF, b=8'h01 -> sum=8'h00, cout=1; the outputs hold through a following 5-cycle idle period.
REQ-027 start held high continuously with a=8'h03, b=8'h04 -> sum=8'h07 at done; start is ignored in RUN and DONE; the next operation is accepted on the first IDLE edge; done pulses are 1 cycle each, spaced 10 edges apart.
REQ-028 rst asserted asynchronously 4 cycles into RUN -> all outputs 0 immediately; no done pulse; a subsequent start with a=8'h20, b=8'h22 gives sum=8'h42, cout=0.
REQ-029 SERIAL_ADDER_SUB_EN defined, sub=1, a=8'h05, b=8'h07 -> sum=8'hFE, cout=0; sub=1, a=8'h07, b=8'h05 -> sum=8'h02, cout=1.
